// File: rtl/turf_aurora_link_manager.sv
// Aurora link supervisor: drives the reset block, qualifies channel_up, retries with backoff.
// Optional LINK_STATS_EN adds drop/timeout statistics counters.
module turf_aurora_link_manager #(
    parameter string       SIM_SPEEDUP = "FALSE",
    parameter logic [47:0] UP_TIMEOUT  = 48'h800_0000,
    parameter int          UP_STABLE   = 1024,
    parameter int          PULSE_LEN   = 16,
    parameter int          MAX_BACKOFF = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       channel_up_i,
    input  logic       sw_reset_i,
    input  logic       auto_en_i,
    output logic       reset_o,
    output logic       link_ok_o,
    output logic [1:0] state_o,
    output logic [7:0] retry_count_o
`ifdef LINK_STATS_EN
    ,
    output logic [15:0] drop_count_o,
    output logic [15:0] timeout_count_o
`endif
);

    localparam logic [47:0] TIMEOUT_BASE = (SIM_SPEEDUP == "TRUE") ? 48'h100 : UP_TIMEOUT;
    localparam int          STABLE_CYC   = (SIM_SPEEDUP == "TRUE") ? 16 : UP_STABLE;
    // The WAIT_UP cycle that first sees ch_up is the first stable sample,
    // so STABLE itself only has to count the remaining STABLE_CYC-1 samples.
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYC - 2);
    localparam logic [7:0]  PULSE_LAST   = 8'(PULSE_LEN - 1);
    localparam logic [7:0]  BACKOFF_MAX  = 8'(MAX_BACKOFF);

    typedef enum logic [1:0] {
        WAIT_UP = 2'd0,
        STABLE  = 2'd1,
        UP      = 2'd2,
        PULSE   = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [47:0] timer, timer_n;
    logic [15:0] stable_cnt, stable_n;
    logic [7:0]  pulse_cnt, pulse_n;
    logic [7:0]  backoff, backoff_n;
    logic [7:0]  retry_count, retry_n;
    logic [1:0]  sync_q;
    logic        sw_q;
    logic        reset_q;
    logic        ch_up;
    logic        sw_edge;
    logic        timeout_evt;
    logic        drop_evt;
    logic [95:0] limit_wide;
    logic [47:0] limit;
    logic [47:0] limit_last;

    assign ch_up   = sync_q[1];
    assign sw_edge = sw_reset_i & ~sw_q;

    // Wide shift so any bit pushed past bit 47 is detected and saturates the limit.
    always_comb begin
        limit_wide = {48'd0, TIMEOUT_BASE} << backoff;
        if (backoff >= 8'd48 || limit_wide[95:48] != 48'd0) begin
            limit = '1;
        end else begin
            limit = limit_wide[47:0];
        end
        limit_last = limit - 48'd1;
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        stable_n    = stable_cnt;
        pulse_n     = pulse_cnt;
        backoff_n   = backoff;
        retry_n     = retry_count;
        timeout_evt = 1'b0;
        drop_evt    = 1'b0;
        case (state)
            WAIT_UP: begin
                timer_n = timer + 48'd1;
                if (sw_edge) begin
                    state_n = PULSE;
                    pulse_n = 8'd0;
                end else if (timer == limit_last) begin
                    timeout_evt = 1'b1;
                    if (auto_en_i) begin
                        state_n   = PULSE;
                        pulse_n   = 8'd0;
                        retry_n   = (retry_count == 8'hFF) ? 8'hFF : retry_count + 8'd1;
                        backoff_n = (backoff < BACKOFF_MAX) ? backoff + 8'd1 : BACKOFF_MAX;
                    end else begin
                        timer_n = timer;
                    end
                end else if (ch_up) begin
                    state_n  = STABLE;
                    stable_n = 16'd0;
                end
            end
            STABLE: begin
                if (sw_edge) begin
                    state_n = PULSE;
                    pulse_n = 8'd0;
                end else if (!ch_up) begin
                    state_n = WAIT_UP;
                    timer_n = 48'd0;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_n   = UP;
                    backoff_n = 8'd0;
                    retry_n   = 8'd0;
                end else begin
                    stable_n = stable_cnt + 16'd1;
                end
            end
            UP: begin
                if (sw_edge) begin
                    state_n  = PULSE;
                    pulse_n  = 8'd0;
                    drop_evt = 1'b1;
                end else if (!ch_up) begin
                    drop_evt = 1'b1;
                    if (auto_en_i) begin
                        state_n = PULSE;
                        pulse_n = 8'd0;
                    end else begin
                        state_n = WAIT_UP;
                        timer_n = 48'd0;
                    end
                end
            end
            PULSE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_n = WAIT_UP;
                    timer_n = 48'd0;
                end else begin
                    pulse_n = pulse_cnt + 8'd1;
                end
            end
            default: state_n = WAIT_UP;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= WAIT_UP;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer       <= 48'd0;
            stable_cnt  <= 16'd0;
            pulse_cnt   <= 8'd0;
            backoff     <= 8'd0;
            retry_count <= 8'd0;
            sync_q      <= 2'b00;
            sw_q        <= 1'b0;
            reset_q     <= 1'b0;
        end else begin
            timer       <= timer_n;
            stable_cnt  <= stable_n;
            pulse_cnt   <= pulse_n;
            backoff     <= backoff_n;
            retry_count <= retry_n;
            sync_q      <= {sync_q[0], channel_up_i};
            sw_q        <= sw_reset_i;
            reset_q     <= (state_n == PULSE);
        end
    end

`ifdef LINK_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] timeout_cnt;
    logic        hold_q;

    // A timeout held with auto_en_i low is counted once, not every held cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt    <= 16'd0;
            timeout_cnt <= 16'd0;
            hold_q      <= 1'b0;
        end else begin
            hold_q <= timeout_evt & ~auto_en_i;
            if (drop_evt && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (timeout_evt && !hold_q && timeout_cnt != 16'hFFFF) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end

    assign drop_count_o    = drop_cnt;
    assign timeout_count_o = timeout_cnt;
`else
    logic unused_evt;
    assign unused_evt = timeout_evt ^ drop_evt;
`endif

    assign reset_o       = reset_q;
    assign link_ok_o     = (state == UP);
    assign state_o       = state;
    assign retry_count_o = retry_count;

endmodule
